// File: rtl/int_service.sv
// 8259 in-service register, priority resolver and two-pulse INTA sequencer.
// Define INT_SERVICE_POLL_EN to add the poll_command / poll_data poll path.
module int_service (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write_initial_command_word_1,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       special_mask_mode,
    input  logic       auto_eoi_config,
    input  logic       auto_rotate_mode,
    input  logic       interrupt_acknowledge_n,
    input  logic       non_specific_eoi,
    input  logic       specific_eoi,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    input  logic       set_priority,
`ifdef INT_SERVICE_POLL_EN
    input  logic       poll_command,
    output logic [7:0] poll_data,
`endif
    output logic       interrupt,
    output logic       freeze,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [2:0] acknowledged_level,
    output logic       vector_valid
);

    typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

    state_t     state, state_d;
    logic       inta_prev, fall, rise;
    logic [2:0] lowest_priority, lp_d;
    logic [7:0] isr_d, ack_set, eoi_clr, aeoi_clr, clr_d;
    logic [7:0] req_vec, isr_vis;
    logic [2:0] level_d, win_level, isr_level, top_level;
    logic       win_found, isr_found, top_found;
    logic       freeze_d, spurious, spurious_d, vv_d, int_cond, int_d;
`ifdef INT_SERVICE_POLL_EN
    logic [7:0] poll_d;
`endif

    // Rotating scan starting just above lowest_priority; returns {found, level}.
    function automatic logic [3:0] resolve(input logic [7:0] vec, input logic [2:0] lp);
        logic [3:0] res;
        logic [2:0] idx;
        res = {1'b0, 3'd7};
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = lp + 3'(i);
            if (!res[3] && vec[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

    assign fall = inta_prev & ~interrupt_acknowledge_n;
    assign rise = ~inta_prev & interrupt_acknowledge_n;

    // Special mask mode hides masked in-service levels and excludes lines already in service.
    assign req_vec = interrupt_request_register & ~interrupt_mask
                     & (special_mask_mode ? ~in_service_register : 8'hFF);
    assign isr_vis = special_mask_mode ? (in_service_register & ~interrupt_mask)
                                       : in_service_register;

    assign {win_found, win_level} = resolve(req_vec, lowest_priority);
    assign {isr_found, isr_level} = resolve(isr_vis, lowest_priority);
    assign {top_found, top_level} = resolve(in_service_register, lowest_priority);

    assign int_cond = win_found &&
                      (!isr_found || rank(win_level, lowest_priority) < rank(isr_level, lowest_priority));

    always_comb begin
        state_d    = state;
        freeze_d   = freeze;
        level_d    = acknowledged_level;
        spurious_d = spurious;
        lp_d       = lowest_priority;
        clr_d      = '0;
        vv_d       = 1'b0;
        ack_set    = '0;
        eoi_clr    = '0;
        aeoi_clr   = '0;
`ifdef INT_SERVICE_POLL_EN
        poll_d     = poll_data;
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    state_d  = ACK1;
                    freeze_d = 1'b1;
                    if (win_found) begin
                        level_d    = win_level;
                        spurious_d = 1'b0;
                        ack_set    = 8'b1 << win_level;
                        clr_d      = 8'b1 << win_level;
                    end else begin
                        level_d    = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
`ifdef INT_SERVICE_POLL_EN
                else if (poll_command) begin
                    poll_d = {win_found, 4'b0, win_level};
                    if (win_found) begin
                        level_d = win_level;
                        ack_set = 8'b1 << win_level;
                        clr_d   = 8'b1 << win_level;
                    end
                end
`endif
            end
            ACK1:  if (rise) state_d = WAIT2;
            WAIT2: begin
                if (fall) begin
                    state_d = ACK2;
                    vv_d    = 1'b1;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_d  = IDLE;
                    freeze_d = 1'b0;
                    if (auto_eoi_config && !spurious) begin
                        aeoi_clr = 8'b1 << acknowledged_level;
                        if (auto_rotate_mode) lp_d = acknowledged_level;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (specific_eoi) begin
            eoi_clr = 8'b1 << eoi_level;
            if (rotate_on_eoi) lp_d = eoi_level;
        end else if (non_specific_eoi && top_found) begin
            eoi_clr = 8'b1 << top_level;
            if (rotate_on_eoi) lp_d = top_level;
        end
        if (set_priority) lp_d = eoi_level;

        // Acknowledge set is OR-ed last so it wins over a same-bit clear.
        isr_d = (in_service_register & ~eoi_clr & ~aeoi_clr) | ack_set;
        int_d = int_cond & ~freeze_d;

        // Init word behaves like a one-cycle synchronous reset.
        if (write_initial_command_word_1) begin
            state_d    = IDLE;
            freeze_d   = 1'b0;
            level_d    = 3'd7;
            spurious_d = 1'b0;
            lp_d       = 3'd7;
            clr_d      = '0;
            vv_d       = 1'b0;
            isr_d      = '0;
            int_d      = 1'b0;
`ifdef INT_SERVICE_POLL_EN
            poll_d     = '0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            inta_prev               <= 1'b1;
            lowest_priority         <= 3'd7;
            in_service_register     <= '0;
            acknowledged_level      <= 3'd7;
            spurious                <= 1'b0;
            freeze                  <= 1'b0;
            interrupt               <= 1'b0;
            clear_interrupt_request <= '0;
            vector_valid            <= 1'b0;
`ifdef INT_SERVICE_POLL_EN
            poll_data               <= '0;
`endif
        end else begin
            state                   <= state_d;
            inta_prev               <= interrupt_acknowledge_n | write_initial_command_word_1;
            lowest_priority         <= lp_d;
            in_service_register     <= isr_d;
            acknowledged_level      <= level_d;
            spurious                <= spurious_d;
            freeze                  <= freeze_d;
            interrupt               <= int_d;
            clear_interrupt_request <= clr_d;
            vector_valid            <= vv_d;
`ifdef INT_SERVICE_POLL_EN
            poll_data               <= poll_d;
`endif
        end
    end

endmodule

// File: tb/tb_int_service.sv
// Directed self-checking bench for int_service (default build, poll feature off).
module tb_int_service;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       write_initial_command_word_1 = 1'b0;
    logic [7:0] interrupt_request_register = '0;
    logic [7:0] interrupt_mask = '0;
    logic       special_mask_mode = 1'b0;
    logic       auto_eoi_config = 1'b0;
    logic       auto_rotate_mode = 1'b0;
    logic       interrupt_acknowledge_n = 1'b1;
    logic       non_specific_eoi = 1'b0;
    logic       specific_eoi = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       rotate_on_eoi = 1'b0;
    logic       set_priority = 1'b0;
    logic       interrupt;
    logic       freeze;
    logic [7:0] clear_interrupt_request;
    logic [7:0] in_service_register;
    logic [2:0] acknowledged_level;
    logic       vector_valid;

    int compared = 0;
    int mismatched = 0;

    int_service dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .write_initial_command_word_1 (write_initial_command_word_1),
        .interrupt_request_register   (interrupt_request_register),
        .interrupt_mask               (interrupt_mask),
        .special_mask_mode            (special_mask_mode),
        .auto_eoi_config              (auto_eoi_config),
        .auto_rotate_mode             (auto_rotate_mode),
        .interrupt_acknowledge_n      (interrupt_acknowledge_n),
        .non_specific_eoi             (non_specific_eoi),
        .specific_eoi                 (specific_eoi),
        .eoi_level                    (eoi_level),
        .rotate_on_eoi                (rotate_on_eoi),
        .set_priority                 (set_priority),
        .interrupt                    (interrupt),
        .freeze                       (freeze),
        .clear_interrupt_request      (clear_interrupt_request),
        .in_service_register          (in_service_register),
        .acknowledged_level           (acknowledged_level),
        .vector_valid                 (vector_valid)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic inta_edge(input logic v);
        interrupt_acknowledge_n = v;
        tick();
    endtask

    task automatic do_init();
        write_initial_command_word_1 = 1'b1;
        tick();
        write_initial_command_word_1 = 1'b0;
    endtask

    task automatic test_reset();
        #22 reset_n = 1'b1;
        tick();
        compared++; if (in_service_register !== 8'h00) begin mismatched++; $display("FAIL reset_isr got %h want 00", in_service_register); end
        compared++; if (acknowledged_level !== 3'd7) begin mismatched++; $display("FAIL reset_level got %0d want 7", acknowledged_level); end
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("FAIL reset_int got %b want 0", interrupt); end
        compared++; if (freeze !== 1'b0) begin mismatched++; $display("FAIL reset_freeze got %b want 0", freeze); end
        compared++; if (clear_interrupt_request !== 8'h00) begin mismatched++; $display("FAIL reset_clr got %h want 00", clear_interrupt_request); end
        compared++; if (vector_valid !== 1'b0) begin mismatched++; $display("FAIL reset_vv got %b want 0", vector_valid); end
    endtask

    task automatic test_basic_ack();
        interrupt_request_register = 8'h04;
        tick();
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("FAIL basic_int got %b want 1", interrupt); end
        inta_edge(1'b0);
        compared++; if (freeze !== 1'b1) begin mismatched++; $display("FAIL basic_freeze1 got %b want 1", freeze); end
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("FAIL basic_int_frozen got %b want 0", interrupt); end
        compared++; if (in_service_register !== 8'h04) begin mismatched++; $display("FAIL basic_isr got %h want 04", in_service_register); end
        compared++; if (clear_interrupt_request !== 8'h04) begin mismatched++; $display("FAIL basic_clr got %h want 04", clear_interrupt_request); end
        compared++; if (acknowledged_level !== 3'd2) begin mismatched++; $display("FAIL basic_level got %0d want 2", acknowledged_level); end
        compared++; if (vector_valid !== 1'b0) begin mismatched++; $display("FAIL basic_vv_early got %b want 0", vector_valid); end
        inta_edge(1'b1);
        compared++; if (clear_interrupt_request !== 8'h00) begin mismatched++; $display("FAIL basic_clr_pulse got %h want 00", clear_interrupt_request); end
        compared++; if (freeze !== 1'b1) begin mismatched++; $display("FAIL basic_freeze_wait got %b want 1", freeze); end
        inta_edge(1'b0);
        compared++; if (vector_valid !== 1'b1) begin mismatched++; $display("FAIL basic_vv got %b want 1", vector_valid); end
        inta_edge(1'b1);
        compared++; if (vector_valid !== 1'b0) begin mismatched++; $display("FAIL basic_vv_once got %b want 0", vector_valid); end
        compared++; if (freeze !== 1'b0) begin mismatched++; $display("FAIL basic_freeze_end got %b want 0", freeze); end
        compared++; if (in_service_register !== 8'h04) begin mismatched++; $display("FAIL basic_isr_hold got %h want 04", in_service_register); end
        tick();
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("FAIL basic_int_same_level got %b want 0", interrupt); end
    endtask

    task automatic test_nested_eoi();
        interrupt_request_register = 8'h01;
        tick();
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("FAIL nest_higher got %b want 1", interrupt); end
        interrupt_request_register = 8'h10;
        tick();
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("FAIL nest_lower got %b want 0", interrupt); end
        non_specific_eoi = 1'b1;
        tick();
        non_specific_eoi = 1'b0;
        compared++; if (in_service_register !== 8'h00) begin mismatched++; $display("FAIL nseoi_isr got %h want 00", in_service_register); end
        tick();
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("FAIL nseoi_int got %b want 1", interrupt); end
    endtask

    task automatic test_init();
        inta_edge(1'b0);
        compared++; if (in_service_register !== 8'h10) begin mismatched++; $display("FAIL init_pre_isr got %h want 10", in_service_register); end
        interrupt_acknowledge_n = 1'b1;
        interrupt_request_register = 8'h00;
        do_init();
        compared++; if (freeze !== 1'b0) begin mismatched++; $display("FAIL init_freeze got %b want 0", freeze); end
        compared++; if (in_service_register !== 8'h00) begin mismatched++; $display("FAIL init_isr got %h want 00", in_service_register); end
        compared++; if (acknowledged_level !== 3'd7) begin mismatched++; $display("FAIL init_level got %0d want 7", acknowledged_level); end
    endtask

    task automatic test_aeoi_rotate();
        auto_eoi_config = 1'b1;
        auto_rotate_mode = 1'b1;
        interrupt_request_register = 8'h08;
        inta_edge(1'b0);
        compared++; if (acknowledged_level !== 3'd3) begin mismatched++; $display("FAIL aeoi_level got %0d want 3", acknowledged_level); end
        compared++; if (in_service_register !== 8'h08) begin mismatched++; $display("FAIL aeoi_isr_set got %h want 08", in_service_register); end
        inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
        compared++; if (in_service_register !== 8'h00) begin mismatched++; $display("FAIL aeoi_isr_clr got %h want 00", in_service_register); end
        interrupt_request_register = 8'h09;
        inta_edge(1'b0);
        compared++; if (acknowledged_level !== 3'd0) begin mismatched++; $display("FAIL rot3_level got %0d want 0", acknowledged_level); end
        inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
        interrupt_request_register = 8'h11;
        inta_edge(1'b0);
        compared++; if (acknowledged_level !== 3'd4) begin mismatched++; $display("FAIL rot0_level got %0d want 4", acknowledged_level); end
        inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
        auto_eoi_config = 1'b0;
        auto_rotate_mode = 1'b0;
        interrupt_request_register = 8'h00;
        do_init();
    endtask

    task automatic test_spurious();
        interrupt_request_register = 8'h00;
        inta_edge(1'b0);
        compared++; if (freeze !== 1'b1) begin mismatched++; $display("FAIL spur_freeze got %b want 1", freeze); end
        compared++; if (acknowledged_level !== 3'd7) begin mismatched++; $display("FAIL spur_level got %0d want 7", acknowledged_level); end
        compared++; if (clear_interrupt_request !== 8'h00) begin mismatched++; $display("FAIL spur_clr got %h want 00", clear_interrupt_request); end
        compared++; if (in_service_register !== 8'h00) begin mismatched++; $display("FAIL spur_isr got %h want 00", in_service_register); end
        inta_edge(1'b1);
        inta_edge(1'b0);
        compared++; if (vector_valid !== 1'b1) begin mismatched++; $display("FAIL spur_vv got %b want 1", vector_valid); end
        inta_edge(1'b1);
        compared++; if (freeze !== 1'b0) begin mismatched++; $display("FAIL spur_freeze_end got %b want 0", freeze); end
    endtask

    task automatic test_specific_eoi();
        interrupt_request_register = 8'h20;
        inta_edge(1'b0); inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
        interrupt_request_register = 8'h04;
        inta_edge(1'b0); inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
        compared++; if (in_service_register !== 8'h24) begin mismatched++; $display("FAIL seoi_pre_isr got %h want 24", in_service_register); end
        interrupt_request_register = 8'h00;
        specific_eoi = 1'b1;
        eoi_level = 3'd5;
        rotate_on_eoi = 1'b1;
        tick();
        specific_eoi = 1'b0;
        rotate_on_eoi = 1'b0;
        compared++; if (in_service_register !== 8'h04) begin mismatched++; $display("FAIL seoi_isr got %h want 04", in_service_register); end
        interrupt_request_register = 8'h41;
        tick();
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("FAIL seoi_rot_int got %b want 1", interrupt); end
        inta_edge(1'b0);
        compared++; if (acknowledged_level !== 3'd6) begin mismatched++; $display("FAIL seoi_rot_level got %0d want 6", acknowledged_level); end
        inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
        interrupt_request_register = 8'h00;
        do_init();
    endtask

    task automatic test_special_mask();
        interrupt_request_register = 8'h04;
        inta_edge(1'b0); inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
        interrupt_request_register = 8'h08;
        interrupt_mask = 8'h04;
        tick(); tick();
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("FAIL smm_off_int got %b want 0", interrupt); end
        special_mask_mode = 1'b1;
        tick();
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("FAIL smm_on_int got %b want 1", interrupt); end
        special_mask_mode = 1'b0;
        interrupt_mask = 8'h00;
        interrupt_request_register = 8'h00;
        do_init();
    endtask

    task automatic test_async_reset();
        interrupt_request_register = 8'h02;
        inta_edge(1'b0);
        inta_edge(1'b1);
        compared++; if (freeze !== 1'b1) begin mismatched++; $display("FAIL arst_pre_freeze got %b want 1", freeze); end
        #2 reset_n = 1'b0;
        #1;
        compared++; if (freeze !== 1'b0) begin mismatched++; $display("FAIL arst_freeze got %b want 0", freeze); end
        compared++; if (in_service_register !== 8'h00) begin mismatched++; $display("FAIL arst_isr got %h want 00", in_service_register); end
        compared++; if (acknowledged_level !== 3'd7) begin mismatched++; $display("FAIL arst_level got %0d want 7", acknowledged_level); end
        #2 reset_n = 1'b1;
        inta_edge(1'b0);
        compared++; if (acknowledged_level !== 3'd1) begin mismatched++; $display("FAIL arst_idle_level got %0d want 1", acknowledged_level); end
        compared++; if (in_service_register !== 8'h02) begin mismatched++; $display("FAIL arst_idle_isr got %h want 02", in_service_register); end
        inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
    endtask

    task automatic test_back_to_back();
        specific_eoi = 1'b1;
        eoi_level = 3'd1;
        inta_edge(1'b0);
        specific_eoi = 1'b0;
        compared++; if (in_service_register !== 8'h02) begin mismatched++; $display("FAIL same_bit_isr got %h want 02", in_service_register); end
        inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
        interrupt_request_register = 8'h01;
        non_specific_eoi = 1'b1;
        inta_edge(1'b0);
        non_specific_eoi = 1'b0;
        compared++; if (in_service_register !== 8'h01) begin mismatched++; $display("FAIL diff_bit_isr got %h want 01", in_service_register); end
        compared++; if (acknowledged_level !== 3'd0) begin mismatched++; $display("FAIL diff_bit_level got %0d want 0", acknowledged_level); end
        inta_edge(1'b1); inta_edge(1'b0); inta_edge(1'b1);
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_nested_eoi();
        test_init();
        test_aeoi_rotate();
        test_spurious();
        test_specific_eoi();
        test_special_mask();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
